layer_init_loader: RTL and testbench

Load sequencer that feeds LayerParaScaleFloat16 with weight beats and initial feature-map tiles. It consumes a flat float16 element stream and packs it into PARA_KERNEL weight kernels and PARA_X×PARA_Y feature-map tiles. It drives the write addresses and the `weight_data_done` / `init_fm_data_done` flags. Once the accelerator reports both RAMs ready, it switches `layer_type` to the configured layer and waits for `layer_ready`.

---
 rtl/layer_init_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_layer_init_loader.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_init_loader.sv
// Load sequencer: packs a float16 element stream into weight beats and
// feature-map tiles, then issues the configured layer to the accelerator.
module layer_init_loader #(
    parameter int DATA_WIDTH              = 16,
    parameter int PARA_X                  = 3,
    parameter int PARA_Y                  = 3,
    parameter int KERNEL_SIZE_MAX         = 3,
    parameter int PARA_KERNEL             = 2,
    parameter int WRITE_ADDR_WIDTH        = 10,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = 8,
    parameter int FM_SIZE_WIDTH           = 8,
    parameter int KERNEL_SIZE_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH:0] cfg_weight_beats,
    input  logic [WRITE_ADDR_WIDTH:0]    cfg_fm_tiles,
    input  logic [1:0]                   cfg_layer_type,
    input  logic [FM_SIZE_WIDTH-1:0]     cfg_fm_size,
    input  logic [KERNEL_SIZE_WIDTH-1:0] cfg_fm_depth,
    input  logic [KERNEL_SIZE_WIDTH-1:0] cfg_kernel_size,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [1:0]                   layer_type,
    output logic [FM_SIZE_WIDTH-1:0]     fm_size,
    output logic [KERNEL_SIZE_WIDTH-1:0] fm_depth,
    output logic [KERNEL_SIZE_WIDTH-1:0] kernel_size,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] init_fm_data,
    output logic [WRITE_ADDR_WIDTH-1:0]  write_fm_data_addr,
    output logic                         fm_wr_en,
    output logic                         init_fm_data_done,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
    output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
    output logic                         weight_wr_en,
    output logic                         weight_data_done,
    input  logic                         init_fm_ram_ready,
    input  logic                         init_weight_ram_ready,
    input  logic                         layer_ready,
    output logic                         busy,
    output logic                         load_done
);

    localparam int DW    = DATA_WIDTH;
    localparam int K2    = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int WG    = K2 * PARA_KERNEL;
    localparam int FG    = PARA_X * PARA_Y;
    localparam int NSLOT = (WG > FG) ? WG : FG;
    localparam int SUBN  = (K2 > FG) ? K2 : FG;
    localparam int SW    = (SUBN > 1) ? $clog2(SUBN) : 1;
    localparam int KW    = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;
    localparam int WWA   = WEIGHT_WRITE_ADDR_WIDTH;
    localparam int WA    = WRITE_ADDR_WIDTH;
    localparam int GW    = WRITE_ADDR_WIDTH + 1;

    localparam logic [SW-1:0] SUB_W_LAST = SW'(K2 - 1);
    localparam logic [SW-1:0] SUB_F_LAST = SW'(FG - 1);
    localparam logic [KW-1:0] KER_LAST   = KW'(PARA_KERNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_FM,
        S_FM_DONE,
        S_WAIT_RDY,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [WWA:0]               cfg_beats_q, cfg_beats_d;
    logic [WA:0]                cfg_tiles_q, cfg_tiles_d;
    logic [1:0]                 cfg_lt_q, cfg_lt_d;
    logic [FM_SIZE_WIDTH-1:0]   cfg_size_q, cfg_size_d;
    logic [KERNEL_SIZE_WIDTH-1:0] cfg_depth_q, cfg_depth_d;
    logic [KERNEL_SIZE_WIDTH-1:0] cfg_ks_q, cfg_ks_d;

    logic [SW-1:0]              sub_q, sub_d;
    logic [KW-1:0]              ker_q, ker_d;
    logic [GW-1:0]              grp_q, grp_d;
    logic [NSLOT*DW-1:0]        buf_q, buf_d;

    logic [WG*DW-1:0]           wdata_q, wdata_d;
    logic [WWA-1:0]             waddr_q, waddr_d;
    logic                       wwr_q, wwr_d;
    logic                       wdone_q, wdone_d;
    logic [FG*DW-1:0]           fdata_q, fdata_d;
    logic [WA-1:0]              faddr_q, faddr_d;
    logic                       fwr_q, fwr_d;
    logic                       fdone_q, fdone_d;

    logic [1:0]                 lt_q, lt_d;
    logic [FM_SIZE_WIDTH-1:0]   size_q, size_d;
    logic [KERNEL_SIZE_WIDTH-1:0] depth_q, depth_d;
    logic [KERNEL_SIZE_WIDTH-1:0] ks_q, ks_d;
    logic                       load_done_q, load_done_d;

    logic                       accept;
    logic                       tiles_zero;
    logic                       w_kern_end;
    logic                       w_beat_end;
    logic                       f_tile_end;
    logic [GW-1:0]              grp_inc;
    logic                       w_final;
    logic                       f_final;
    logic                       rams_ready;
    int                         slot;

    assign accept     = s_valid && s_ready;
    assign tiles_zero = (cfg_tiles_q == '0);
    assign w_kern_end = (sub_q == SUB_W_LAST);
    assign w_beat_end = w_kern_end && (ker_q == KER_LAST);
    assign f_tile_end = (sub_q == SUB_F_LAST);
    assign grp_inc    = grp_q + 1'b1;
    assign w_final    = (grp_inc == GW'(cfg_beats_q));
    assign f_final    = (grp_inc == cfg_tiles_q);
    assign rams_ready = init_fm_ram_ready && init_weight_ram_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cfg_weight_beats == '0) ? S_LOAD_FM : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (accept && w_beat_end && w_final) begin
                    state_d = S_LOAD_FM;
                end
            end
            S_LOAD_FM: begin
                if (tiles_zero || (accept && f_tile_end && f_final)) begin
                    state_d = S_FM_DONE;
                end
            end
            S_FM_DONE:  state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (rams_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (layer_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; a zero-tile load never opens the stream
    always_comb begin
        s_ready = (state_q == S_LOAD_W) ||
                  ((state_q == S_LOAD_FM) && !tiles_zero);
        busy    = (state_q != S_IDLE);
    end

    // Slot of the incoming element: kernel 0 low, first element at the top
    always_comb begin
        if (state_q == S_LOAD_W) begin
            slot = int'(ker_q) * K2 + (K2 - 1) - int'(sub_q);
        end else begin
            slot = (FG - 1) - int'(sub_q);
        end
    end

    // Datapath next-state: packing, write strobes, flags and layer issue
    always_comb begin
        cfg_beats_d = cfg_beats_q;
        cfg_tiles_d = cfg_tiles_q;
        cfg_lt_d    = cfg_lt_q;
        cfg_size_d  = cfg_size_q;
        cfg_depth_d = cfg_depth_q;
        cfg_ks_d    = cfg_ks_q;
        sub_d       = sub_q;
        ker_d       = ker_q;
        grp_d       = grp_q;
        buf_d       = buf_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        wwr_d       = 1'b0;
        wdone_d     = wdone_q;
        fdata_d     = fdata_q;
        faddr_d     = faddr_q;
        fwr_d       = 1'b0;
        fdone_d     = fdone_q;
        lt_d        = lt_q;
        size_d      = size_q;
        depth_d     = depth_q;
        ks_d        = ks_q;
        load_done_d = 1'b0;

        if (accept) begin
            for (int e = 0; e < NSLOT; e++) begin
                if (e == slot) begin
                    buf_d[e*DW +: DW] = s_data;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_beats_d = cfg_weight_beats;
                    cfg_tiles_d = cfg_fm_tiles;
                    cfg_lt_d    = cfg_layer_type;
                    cfg_size_d  = cfg_fm_size;
                    cfg_depth_d = cfg_fm_depth;
                    cfg_ks_d    = cfg_kernel_size;
                    sub_d       = '0;
                    ker_d       = '0;
                    grp_d       = '0;
                    wdone_d     = (cfg_weight_beats == '0);
                    fdone_d     = 1'b0;
                    lt_d        = 2'd0;
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    if (!w_kern_end) begin
                        sub_d = sub_q + 1'b1;
                    end else begin
                        sub_d = '0;
                        if (!w_beat_end) begin
                            ker_d = ker_q + 1'b1;
                        end else begin
                            ker_d   = '0;
                            wdata_d = buf_d[WG*DW-1:0];
                            waddr_d = grp_q[WWA-1:0];
                            wwr_d   = 1'b1;
                            grp_d   = w_final ? '0 : grp_inc;
                        end
                    end
                end
            end
            S_LOAD_FM: begin
                // first LOAD_FM edge is one cycle after the final weight write
                wdone_d = 1'b1;
                if (tiles_zero) begin
                    fdone_d = 1'b1;
                end
                if (accept) begin
                    if (!f_tile_end) begin
                        sub_d = sub_q + 1'b1;
                    end else begin
                        sub_d   = '0;
                        fdata_d = buf_d[FG*DW-1:0];
                        faddr_d = grp_q[WA-1:0];
                        fwr_d   = 1'b1;
                        grp_d   = grp_inc;
                    end
                end
            end
            S_FM_DONE: begin
                fdone_d = 1'b1;
            end
            S_WAIT_RDY: begin
                if (rams_ready) begin
                    lt_d    = cfg_lt_q;
                    size_d  = cfg_size_q;
                    depth_d = cfg_depth_q;
                    ks_d    = cfg_ks_q;
                end
            end
            S_RUN: begin
                if (layer_ready) begin
                    load_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_beats_q <= '0;
            cfg_tiles_q <= '0;
            cfg_lt_q    <= '0;
            cfg_size_q  <= '0;
            cfg_depth_q <= '0;
            cfg_ks_q    <= '0;
            sub_q       <= '0;
            ker_q       <= '0;
            grp_q       <= '0;
            buf_q       <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            wwr_q       <= 1'b0;
            wdone_q     <= 1'b0;
            fdata_q     <= '0;
            faddr_q     <= '0;
            fwr_q       <= 1'b0;
            fdone_q     <= 1'b0;
            lt_q        <= '0;
            size_q      <= '0;
            depth_q     <= '0;
            ks_q        <= '0;
            load_done_q <= 1'b0;
        end else begin
            cfg_beats_q <= cfg_beats_d;
            cfg_tiles_q <= cfg_tiles_d;
            cfg_lt_q    <= cfg_lt_d;
            cfg_size_q  <= cfg_size_d;
            cfg_depth_q <= cfg_depth_d;
            cfg_ks_q    <= cfg_ks_d;
            sub_q       <= sub_d;
            ker_q       <= ker_d;
            grp_q       <= grp_d;
            buf_q       <= buf_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            wwr_q       <= wwr_d;
            wdone_q     <= wdone_d;
            fdata_q     <= fdata_d;
            faddr_q     <= faddr_d;
            fwr_q       <= fwr_d;
            fdone_q     <= fdone_d;
            lt_q        <= lt_d;
            size_q      <= size_d;
            depth_q     <= depth_d;
            ks_q        <= ks_d;
            load_done_q <= load_done_d;
        end
    end

    assign layer_type             = lt_q;
    assign fm_size                = size_q;
    assign fm_depth               = depth_q;
    assign kernel_size            = ks_q;
    assign init_fm_data           = fdata_q;
    assign write_fm_data_addr     = faddr_q;
    assign fm_wr_en               = fwr_q;
    assign init_fm_data_done      = fdone_q;
    assign weight_data            = wdata_q;
    assign write_weight_data_addr = {PARA_KERNEL{waddr_q}};
    assign weight_wr_en           = wwr_q;
    assign weight_data_done       = wdone_q;
    assign load_done              = load_done_q;

endmodule

// File: tb/tb_layer_init_loader.sv
// Bench for layer_init_loader: scoreboard of packed weight beats and
// fm tiles, plus reset, ready gating, zero counts and restart scenarios.
module tb_layer_init_loader;

    logic clk, rst, start;
    logic [8:0] cfg_weight_beats;
    logic [10:0] cfg_fm_tiles;
    logic [1:0] cfg_layer_type;
    logic [7:0] cfg_fm_size;
    logic [3:0] cfg_fm_depth, cfg_kernel_size;
    logic [15:0] s_data;
    logic s_valid, s_ready;
    logic [1:0] layer_type;
    logic [7:0] fm_size;
    logic [3:0] fm_depth, kernel_size;
    logic [143:0] init_fm_data;
    logic [9:0] write_fm_data_addr;
    logic fm_wr_en, init_fm_data_done;
    logic [287:0] weight_data;
    logic [15:0] write_weight_data_addr;
    logic weight_wr_en, weight_data_done;
    logic init_fm_ram_ready, init_weight_ram_ready, layer_ready;
    logic busy, load_done;

    layer_init_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_weight_beats(cfg_weight_beats), .cfg_fm_tiles(cfg_fm_tiles),
        .cfg_layer_type(cfg_layer_type), .cfg_fm_size(cfg_fm_size),
        .cfg_fm_depth(cfg_fm_depth), .cfg_kernel_size(cfg_kernel_size),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .layer_type(layer_type), .fm_size(fm_size), .fm_depth(fm_depth),
        .kernel_size(kernel_size), .init_fm_data(init_fm_data),
        .write_fm_data_addr(write_fm_data_addr), .fm_wr_en(fm_wr_en),
        .init_fm_data_done(init_fm_data_done), .weight_data(weight_data),
        .write_weight_data_addr(write_weight_data_addr),
        .weight_wr_en(weight_wr_en), .weight_data_done(weight_data_done),
        .init_fm_ram_ready(init_fm_ram_ready),
        .init_weight_ram_ready(init_weight_ram_ready),
        .layer_ready(layer_ready), .busy(busy), .load_done(load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests, fails;
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [482:0] all_out;
    assign all_out = {layer_type, fm_size, fm_depth, kernel_size,
                      init_fm_data, write_fm_data_addr, fm_wr_en,
                      init_fm_data_done, weight_data,
                      write_weight_data_addr, weight_wr_en,
                      weight_data_done, busy, load_done, s_ready};

    // observed writes and flag edges, stamped with the cycle count
    logic [287:0] obs_wd[$];
    logic [15:0]  obs_wa[$];
    logic [143:0] obs_fd[$];
    logic [9:0]   obs_fa[$];
    int last_w_cyc, last_f_cyc, wdone_cyc, fdone_cyc;
    bit wdone_p, fdone_p;
    always @(negedge clk) begin
        if (weight_wr_en) begin
            obs_wd.push_back(weight_data);
            obs_wa.push_back(write_weight_data_addr);
            last_w_cyc = cyc;
        end
        if (fm_wr_en) begin
            obs_fd.push_back(init_fm_data);
            obs_fa.push_back(write_fm_data_addr);
            last_f_cyc = cyc;
        end
        if (weight_data_done && !wdone_p) wdone_cyc = cyc;
        if (init_fm_data_done && !fdone_p) fdone_cyc = cyc;
        wdone_p = weight_data_done;
        fdone_p = init_fm_data_done;
    end

    logic [15:0]  strm[$];
    logic [15:0]  golden[$];
    logic [287:0] exp_wd[$];
    logic [7:0]   exp_wa[$];
    logic [143:0] exp_fd[$];
    logic [9:0]   exp_fa[$];
    int rd_w, rd_f;

    task automatic gen_strm(input int n);
        strm.delete();
        for (int i = 0; i < n; i++) strm.push_back(16'($urandom));
    endtask

    // reference packing: kernel k low-to-high, first element most significant
    task automatic build(input int beats, input int tiles);
        logic [287:0] d;
        logic [143:0] f;
        for (int b = 0; b < beats; b++) begin
            d = '0;
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 9; j++)
                    d[(k*9 + 8 - j)*16 +: 16] = strm[b*18 + k*9 + j];
            exp_wd.push_back(d);
            exp_wa.push_back(8'(b));
        end
        for (int t = 0; t < tiles; t++) begin
            f = '0;
            for (int j = 0; j < 9; j++)
                f[(8 - j)*16 +: 16] = strm[beats*18 + t*9 + j];
            exp_fd.push_back(f);
            exp_fa.push_back(10'(t));
        end
    endtask

    task automatic do_start(input int beats, input int tiles,
                            input logic [1:0] lt, input logic [7:0] sz,
                            input logic [3:0] dp, input logic [3:0] ks);
        @(negedge clk);
        cfg_weight_beats = 9'(beats);
        cfg_fm_tiles     = 11'(tiles);
        cfg_layer_type   = lt;
        cfg_fm_size      = sz;
        cfg_fm_depth     = dp;
        cfg_kernel_size  = ks;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic stream_elems(input int first, input int n,
                                input bit gaps, output bit ok);
        int idx;
        int budget;
        bit acc;
        idx = first;
        budget = n * 20 + 10;
        ok = 1'b1;
        while (idx < first + n) begin
            @(negedge clk);
            if (budget == 0) begin
                ok = 1'b0;
                break;
            end
            budget--;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = strm[idx];
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_run(input logic [1:0] lt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy && layer_type == lt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_layer_ready();
        layer_ready = 1'b1;
        @(negedge clk);
        layer_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        logic [287:0] ed;
        logic [7:0] ea;
        logic [143:0] fd;
        logic [9:0] fa;
        @(negedge clk);
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        gen_strm(18 + 36);
        do_start(1, 4, 2'd1, 8'd8, 4'd2, 4'd3);
        stream_elems(0, 31, 1'b0, ok);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL midload_reset_outputs: got %h want 0", all_out);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midload_reset_busy: got %b want 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        rd_w = obs_wd.size();
        rd_f = obs_fd.size();
        gen_strm(18 + 18);
        build(1, 2);
        do_start(1, 2, 2'd1, 8'd8, 4'd2, 4'd3);
        stream_elems(0, 36, 1'b0, ok);
        wait_run(2'd1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reload_run: got timeout want layer_type 1");
        end
        while (exp_wd.size() > 0) begin
            ed = exp_wd.pop_front();
            ea = exp_wa.pop_front();
            tests++;
            if (rd_w >= obs_wd.size()) begin
                fails++;
                $display("FAIL reload_wbeat: got none want %h@%h", ed, ea);
            end else if (obs_wd[rd_w] !== ed || obs_wa[rd_w] !== {ea, ea}) begin
                fails++;
                $display("FAIL reload_wbeat: got %h@%h want %h@%h",
                         obs_wd[rd_w], obs_wa[rd_w], ed, {ea, ea});
            end
            rd_w++;
        end
        while (exp_fd.size() > 0) begin
            fd = exp_fd.pop_front();
            fa = exp_fa.pop_front();
            tests++;
            if (rd_f >= obs_fd.size()) begin
                fails++;
                $display("FAIL reload_tile: got none want %h@%h", fd, fa);
            end else if (obs_fd[rd_f] !== fd || obs_fa[rd_f] !== fa) begin
                fails++;
                $display("FAIL reload_tile: got %h@%h want %h@%h",
                         obs_fd[rd_f], obs_fa[rd_f], fd, fa);
            end
            rd_f++;
        end
        pulse_layer_ready();
    endtask

    task automatic test_load(input bit gaps);
        bit ok;
        int wb, fb;
        logic [15:0] wk0[9];
        logic [15:0] ft0[9];
        logic [287:0] ed;
        logic [7:0] ea;
        logic [143:0] fd;
        logic [9:0] fa;
        wk0 = '{16'h3c00, 16'h4000, 16'h0000, 16'h3c00, 16'h4000,
                16'h3c00, 16'h4200, 16'h4000, 16'h3c00};
        ft0 = '{16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h3c00,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rd_w = obs_wd.size();
        rd_f = obs_fd.size();
        wb = rd_w;
        fb = rd_f;
        if (!gaps) begin
            gen_strm(198);
            for (int i = 0; i < 9; i++) begin
                strm[i] = wk0[i];
                strm[36 + i] = ft0[i];
            end
            golden = strm;
        end else begin
            strm = golden;
        end
        build(2, 18);
        do_start(2, 18, 2'd1, 8'd8, 4'd2, 4'd3);
        stream_elems(0, 198, gaps, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL load_stream(gaps=%0d): got timeout want 198 accepted", gaps);
        end
        wait_run(2'd1, ok);
        tests++;
        if (!ok || {fm_size, fm_depth, kernel_size} !== {8'd8, 4'd2, 4'd3}) begin
            fails++;
            $display("FAIL load_layer(gaps=%0d): got lt %0d geom %h want lt 1 geom 823",
                     gaps, layer_type, {fm_size, fm_depth, kernel_size});
        end
        if (obs_wd.size() > wb) ed = obs_wd[wb];
        else ed = 'x;
        tests++;
        if (ed[143:0] !== 144'h3c00_4000_0000_3c00_4000_3c00_4200_4000_3c00) begin
            fails++;
            $display("FAIL beat0_kernel0: got %h want 3c00400000003c0040003c0042004000 3c00",
                     ed[143:0]);
        end
        if (obs_fd.size() > fb) fd = obs_fd[fb];
        else fd = 'x;
        tests++;
        if (fd !== 144'h4200_4000_0000_4000_3c00_0000_0000_0000_0000) begin
            fails++;
            $display("FAIL tile0: got %h want 42004000000040003c0000000000000000 00", fd);
        end
        tests++;
        if (obs_wd.size() - wb != 2 || obs_fd.size() - fb != 18) begin
            fails++;
            $display("FAIL write_counts: got %0d/%0d want 2/18",
                     obs_wd.size() - wb, obs_fd.size() - fb);
        end
        tests++;
        if (wdone_cyc - last_w_cyc != 1 || fdone_cyc - last_f_cyc != 1) begin
            fails++;
            $display("FAIL done_timing: got %0d/%0d want 1/1",
                     wdone_cyc - last_w_cyc, fdone_cyc - last_f_cyc);
        end
        while (exp_wd.size() > 0) begin
            ed = exp_wd.pop_front();
            ea = exp_wa.pop_front();
            tests++;
            if (rd_w >= obs_wd.size()) begin
                fails++;
                $display("FAIL wbeat: got none want %h@%h", ed, ea);
            end else if (obs_wd[rd_w] !== ed || obs_wa[rd_w] !== {ea, ea}) begin
                fails++;
                $display("FAIL wbeat: got %h@%h want %h@%h",
                         obs_wd[rd_w], obs_wa[rd_w], ed, {ea, ea});
            end
            rd_w++;
        end
        while (exp_fd.size() > 0) begin
            fd = exp_fd.pop_front();
            fa = exp_fa.pop_front();
            tests++;
            if (rd_f >= obs_fd.size()) begin
                fails++;
                $display("FAIL tile: got none want %h@%h", fd, fa);
            end else if (obs_fd[rd_f] !== fd || obs_fa[rd_f] !== fa) begin
                fails++;
                $display("FAIL tile: got %h@%h want %h@%h",
                         obs_fd[rd_f], obs_fa[rd_f], fd, fa);
            end
            rd_f++;
        end
        pulse_layer_ready();
        tests++;
        if (load_done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL load_complete: got done %b busy %b want 1 0", load_done, busy);
        end
    endtask

    task automatic test_ready_gating();
        bit ok;
        bit bad;
        init_weight_ram_ready = 1'b0;
        gen_strm(27);
        do_start(1, 1, 2'd2, 8'd4, 4'd1, 4'd3);
        stream_elems(0, 27, 1'b0, ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (init_fm_data_done) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gating_fm_done: got timeout want init_fm_data_done");
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (layer_type !== 2'd0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL gating_hold: got layer_type %0d want 0", layer_type);
        end
        init_weight_ram_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (layer_type !== 2'd2 || fm_size !== 8'd4) begin
            fails++;
            $display("FAIL gating_release: got lt %0d size %0d want 2 4",
                     layer_type, fm_size);
        end
    endtask

    task automatic test_completion();
        do_start(1, 1, 2'd3, 8'd9, 4'd9, 4'd9);
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || layer_type !== 2'd2 || weight_data_done !== 1'b1) begin
            fails++;
            $display("FAIL start_while_busy: got busy %b lt %0d wdone %b want 1 2 1",
                     busy, layer_type, weight_data_done);
        end
        pulse_layer_ready();
        tests++;
        if (load_done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL completion: got done %b busy %b want 1 0", load_done, busy);
        end
        @(negedge clk);
        tests++;
        if (load_done !== 1'b0 || layer_type !== 2'd2) begin
            fails++;
            $display("FAIL completion_hold: got done %b lt %0d want 0 2",
                     load_done, layer_type);
        end
    endtask

    task automatic test_zero_counts();
        bit ok;
        int wn, fn;
        wn = obs_wd.size();
        fn = obs_fd.size();
        do_start(0, 0, 2'd3, 8'd1, 4'd1, 4'd1);
        @(negedge clk);
        tests++;
        if (weight_data_done !== 1'b1 || init_fm_data_done !== 1'b0 ||
            layer_type !== 2'd0) begin
            fails++;
            $display("FAIL zero_first: got wdone %b fdone %b lt %0d want 1 0 0",
                     weight_data_done, init_fm_data_done, layer_type);
        end
        @(negedge clk);
        tests++;
        if (init_fm_data_done !== 1'b1) begin
            fails++;
            $display("FAIL zero_fm_done: got %b want 1", init_fm_data_done);
        end
        wait_run(2'd3, ok);
        tests++;
        if (!ok || obs_wd.size() != wn || obs_fd.size() != fn) begin
            fails++;
            $display("FAIL zero_no_writes: got run %b writes %0d/%0d want 1 0/0",
                     ok, obs_wd.size() - wn, obs_fd.size() - fn);
        end
        pulse_layer_ready();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        cfg_weight_beats = '0;
        cfg_fm_tiles = '0;
        cfg_layer_type = '0;
        cfg_fm_size = '0;
        cfg_fm_depth = '0;
        cfg_kernel_size = '0;
        init_fm_ram_ready = 1'b1;
        init_weight_ram_ready = 1'b1;
        layer_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_load(1'b0);
        test_load(1'b1);
        test_ready_gating();
        test_completion();
        test_zero_counts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
